// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared states, opcodes and iteration count for the MULTU/DIVU sequencer
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU = 1'b1;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam int ITER = 32;
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: start/busy/done handshake, HI/LO results and shared-ALU hookup
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic start;
  logic op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0] alu_control;
  logic [WIDTH-1:0] alu_result;
  modport master (output start, op, rs_val, rt_val, alu_result,
                  input busy, done, hi, lo, alu_a, alu_b, alu_control);
  modport slave (input start, op, rs_val, rt_val, alu_result,
                 output busy, done, hi, lo, alu_a, alu_b, alu_control);
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULTU/DIVU sequencer driving a shared ALU (ADD/SUB) into HI/LO.
// Optional MULDIV_ZERO_SKIP_EN: zero-operand cases finish straight from IDLE.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  muldiv_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [$clog2(ITER)-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] shifted;
  logic carry, borrow, last, take;
  assign shifted = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign carry = bus.alu_result < bus.alu_a;
  assign borrow = shifted < opnd_q;
  assign take = hi_q[WIDTH-1] || !borrow;
  assign last = cnt_q == $clog2(ITER)'(ITER - 1);
  assign bus.alu_a = state_q == MUL ? hi_q : state_q == DIV ? shifted : '0;
  assign bus.alu_b = state_q == MUL ? (lo_q[0] ? opnd_q : '0) : state_q == DIV ? opnd_q : '0;
  assign bus.alu_control = state_q == DIV ? ALU_SUB : ALU_ADD;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    opnd_d = opnd_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = bus.op == OP_DIVU ? DIV : MUL;
        cnt_d = '0;
        hi_d = '0;
        lo_d = bus.op == OP_DIVU ? bus.rs_val : bus.rt_val;
        opnd_d = bus.op == OP_DIVU ? bus.rt_val : bus.rs_val;
`ifdef MULDIV_ZERO_SKIP_EN
        if (bus.rt_val == '0 || (bus.op == OP_MULTU && bus.rs_val == '0)) begin
          state_d = DONE;
          hi_d = bus.op == OP_DIVU ? bus.rs_val : '0;
          lo_d = bus.op == OP_DIVU ? '1 : '0;
        end
`endif
      end
      MUL: begin
        hi_d = {carry, bus.alu_result[WIDTH-1:1]};
        lo_d = {bus.alu_result[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        state_d = last ? DONE : MUL;
      end
      DIV: begin
        hi_d = take ? bus.alu_result : shifted;
        lo_d = {lo_q[WIDTH-2:0], take};
        cnt_d = cnt_q + 1'b1;
        state_d = last ? DONE : DIV;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      opnd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      opnd_q <= opnd_d;
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: random MULTU/DIVU traffic against an arithmetic model, scoreboarded on done.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int cyc;
    int busy_n;
  } exp_t;
  exp_t q[$];
  int busy_n = 0;
  muldiv_ctrl_if bus ();
  muldiv_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.alu_result = bus.alu_control == 3'b010 ? bus.alu_a + bus.alu_b :
                          bus.alu_control == 3'b110 ? bus.alu_a - bus.alu_b :
                          bus.alu_control == 3'b000 ? bus.alu_a & bus.alu_b :
                          bus.alu_control == 3'b001 ? bus.alu_a | bus.alu_b :
                          {31'b0, bus.alu_a < bus.alu_b};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    bit skip;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 200);
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", bus.busy, n);
    end
    bus.start = 1'b1;
    bus.op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    if (op) begin
      e.hi = b == 0 ? a : a % b;
      e.lo = b == 0 ? 32'hFFFF_FFFF : a / b;
    end else begin
      p = 64'(a) * 64'(b);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end
    skip = 1'b0;
`ifdef MULDIV_ZERO_SKIP_EN
    skip = b == 0 || (!op && a == 0);
`endif
    e.cyc = skip ? cyc : cyc + 32;
    e.busy_n = skip ? 1 : 33;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (!bus.busy) busy_n = 0;
    else busy_n++;
    if (bus.done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=%b with empty scoreboard at cycle %0d", bus.done, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hi", 64'(bus.hi), 64'(e.hi));
        chk("lo", 64'(bus.lo), 64'(e.lo));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_cycles", 64'(busy_n), 64'(e.busy_n));
      end
    end
  end
  initial begin
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_alu", {bus.alu_a, bus.alu_b[28:0], bus.alu_control}, 64'h2);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 32'd7, 32'd6);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1'b1, 32'd100, 32'd7);
    issue(1'b1, 32'h8000_0000, 32'd3);
    issue(1'b1, 32'd5, 32'd0);
    issue(1'b0, 32'd0, 32'd9);
    issue(1'b0, 32'd3, 32'd4);
    repeat (5) begin
      @(negedge clk);
      bus.op = 1'b1;
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
    end
    issue(1'b1, 32'd100, 32'd7);
    issue(1'b0, 32'hDEAD_BEEF | 32'h1, 32'h1234_5679);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;
    void'(q.pop_back());
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 32'd2, 32'd2);
    for (int i = 0; i < 40; i++) issue(1'($urandom_range(0, 1)), rnd_val(), rnd_val());
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results still outstanding, expected 0", q.size());
    end
    bus.start = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
